// File: rtl/dii_worm_arbiter.sv
// dii_worm_arbiter: packet-aware round-robin N:1 merge for DII flit streams.
// A whole worm (first flit through last=1) is granted to one input before the
// next arbitration. The output is a single register stage that can load and
// unload in the same cycle, so throughput is one flit per cycle.

package dii_worm_arbiter_pkg;

    localparam int unsigned DII_DATA_W = 16;

    // One debug-interconnect flit.
    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [DII_DATA_W-1:0] data;
    } dii_flit;

endpackage

module dii_worm_arbiter
    import dii_worm_arbiter_pkg::*;
#(
    parameter int unsigned PORTS = 4,
    parameter int unsigned PW    = $clog2(PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  dii_flit [PORTS-1:0]  in_flit,
    output logic    [PORTS-1:0]  in_ready,
    output dii_flit              out_flit,
    input  logic                 out_ready,
    output logic                 busy,
    output logic    [PW-1:0]     owner
);

    // One extra bit so prio + offset can be folded back below PORTS.
    localparam int unsigned IW = PW + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [PW-1:0]   prio_q;
    logic [PW-1:0]   prio_d;
    logic [PW-1:0]   owner_q;
    logic [PW-1:0]   owner_d;
    logic            busy_q;

    logic [PW-1:0]   winner;
    logic            win_found;
    logic [IW-1:0]   scan_idx;
    logic [IW-1:0]   inc_idx;

    logic [PW-1:0]   sel;
    dii_flit         sel_flit;
    logic            sel_valid;
    logic            can_load;
    logic            take;

    dii_flit         out_q;

    // Rotating-priority search: first valid port starting at prio, modulo PORTS.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            scan_idx = IW'(prio_q) + IW'(k);
            if (scan_idx >= IW'(PORTS)) begin
                scan_idx = scan_idx - IW'(PORTS);
            end
            if (!win_found && in_flit[PW'(scan_idx)].valid) begin
                win_found = 1'b1;
                winner    = PW'(scan_idx);
            end
        end
    end

    // Select the candidate port and qualify the transfer with output space.
    always_comb begin
        can_load  = !out_q.valid || out_ready;
        sel       = (state_q == LOCKED) ? owner_q : winner;
        sel_flit  = in_flit[sel];
        sel_valid = (state_q == LOCKED) ? sel_flit.valid : win_found;
        take      = rst && sel_valid && can_load;
    end

    // State register: lock state, owner, priority pointer and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            prio_q  <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            busy_q  <= (state_d == LOCKED);
        end
    end

    // Next-state: lock on a non-last first flit, release and rotate on last.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        inc_idx = IW'(sel) + IW'(1);
        if (inc_idx >= IW'(PORTS)) begin
            inc_idx = '0;
        end
        if (take) begin
            if (sel_flit.last) begin
                state_d = IDLE;
                owner_d = '0;
                prio_d  = PW'(inc_idx);
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = sel;
            end
        end
    end

    // Output decode: a single ready bit for the port that transfers this cycle.
    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[sel] = 1'b1;
        end
    end

    // Output register: load on transfer, drain valid when the sink accepts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else if (take) begin
            out_q <= '{valid: 1'b1, last: sel_flit.last, data: sel_flit.data};
        end else if (out_ready) begin
            out_q.valid <= 1'b0;
        end
    end

    assign out_flit = out_q;
    assign busy     = busy_q;
    assign owner    = owner_q;

endmodule
